// File: rtl/ddr_package.sv
// Shared DDR4 controller types: CAS direction, scheduler commands/states, default timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Ports: none.
package ddr_package;

  // CAS direction encoding carried on the cas_rw request qualifier.
  typedef enum logic [1:0] {
    DDR_READ  = 2'b01,
    DDR_WRITE = 2'b10
  } ddr_rw_type;

  // Command placed on the DDR command bus by the scheduler.
  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_PRE  = 3'd1,
    CMD_PREA = 3'd2,
    CMD_ACT  = 3'd3,
    CMD_RD   = 3'd4,
    CMD_WR   = 3'd5,
    CMD_REF  = 3'd6
  } sched_cmd_type;

  typedef enum logic [1:0] {
    SCH_RUN,
    SCH_DRAIN,
    SCH_TRP,
    SCH_TRFC
  } sched_fsm_type;

  // Default DDR4 timing, in controller clocks.
  localparam int DEF_T_RRD        = 4;
  localparam int DEF_T_RP         = 11;
  localparam int DEF_T_RFC        = 208;
  localparam int DEF_T_REFI       = 6240;
  localparam int DEF_MAX_POSTPONE = 8;

  // Width of the owed-refresh count.
  localparam int REF_PEND_W = 4;

  // Any encoding other than WRITE is issued as a read.
  function automatic sched_cmd_type cas_cmd(input logic [1:0] rw);
    return (rw == DDR_WRITE) ? CMD_WR : CMD_RD;
  endfunction

endpackage

// File: rtl/sched_refresh_timer.sv
// Refresh interval counter and owed-refresh bookkeeping for the command scheduler.
// Latency: ref_pending updates the clock after an interval wrap or a REF issue.
// Backpressure: none; refreshes owed beyond MAX_POSTPONE are dropped (count saturates).
// Ports: clock_t/reset_n; ref_issue (REF being issued this cycle);
//        ref_pending (refreshes owed); ref_urgent (owed count at MAX_POSTPONE).
module sched_refresh_timer
  import ddr_package::*;
#(
  parameter int T_REFI       = DEF_T_REFI,
  parameter int MAX_POSTPONE = DEF_MAX_POSTPONE
) (
  input  logic                  clock_t,
  input  logic                  reset_n,
  input  logic                  ref_issue,
  output logic [REF_PEND_W-1:0] ref_pending,
  output logic                  ref_urgent
);

  localparam int                    CW       = (T_REFI > 1) ? $clog2(T_REFI) : 1;
  localparam logic [CW-1:0]         CNT_LAST = CW'(T_REFI - 1);
  localparam logic [REF_PEND_W-1:0] PEND_MAX = REF_PEND_W'(MAX_POSTPONE);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [REF_PEND_W-1:0] pend_q, pend_d;
  logic                  wrap;

  always_comb begin
    wrap   = (cnt_q == CNT_LAST);
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    pend_d = pend_q;
    // A wrap and a REF in the same cycle cancel out.
    if (wrap && !ref_issue) begin
      if (pend_q != PEND_MAX) begin
        pend_d = pend_q + REF_PEND_W'(1);
      end
    end else if (!wrap && ref_issue) begin
      if (pend_q != '0) begin
        pend_d = pend_q - REF_PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign ref_pending = pend_q;
  assign ref_urgent  = (pend_q == PEND_MAX);

endmodule

// File: rtl/ddr_cmd_sched.sv
// DDR command-bus scheduler: one command per clock from CAS/PRE/ACT requesters plus refresh.
// Latency: grant, cmd_valid and cmd are registered one clock after a request is seen.
// Backpressure: ungranted requesters hold req; ACT waits on tRRD, all but CAS wait during refresh.
// Ports: clock_t/reset_n; pre_req/act_req/cas_req (+cas_rw) in; pre_gnt/act_gnt/cas_gnt pulses;
//        cmd_valid/cmd command bus; ref_busy (refresh sequence active); ref_pending (refreshes owed).
module ddr_cmd_sched
  import ddr_package::*;
#(
  parameter int T_RRD        = DEF_T_RRD,
  parameter int T_RP         = DEF_T_RP,
  parameter int T_RFC        = DEF_T_RFC,
  parameter int T_REFI       = DEF_T_REFI,
  parameter int MAX_POSTPONE = DEF_MAX_POSTPONE
) (
  input  logic                  clock_t,
  input  logic                  reset_n,
  input  logic                  pre_req,
  input  logic                  act_req,
  input  logic                  cas_req,
  input  logic [1:0]            cas_rw,
  output logic                  pre_gnt,
  output logic                  act_gnt,
  output logic                  cas_gnt,
  output logic                  cmd_valid,
  output logic [2:0]            cmd,
  output logic                  ref_busy,
  output logic [REF_PEND_W-1:0] ref_pending
);

  localparam int            TMAX      = (T_RFC > T_RP) ? T_RFC : T_RP;
  localparam int            TW        = $clog2(TMAX + 1);
  localparam int            RW        = $clog2(T_RRD + 1);
  localparam logic [TW-1:0] TRP_LAST  = TW'(T_RP - 1);
  localparam logic [TW-1:0] TRFC_LAST = TW'(T_RFC - 1);
  localparam logic [RW-1:0] RRD_LOAD  = RW'(T_RRD - 1);

  sched_fsm_type         state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [RW-1:0]         rrd_q, rrd_d;
  logic                  cas_gnt_q, cas_gnt_d;
  logic                  pre_gnt_q, pre_gnt_d;
  logic                  act_gnt_q, act_gnt_d;
  logic                  cmd_valid_q, cmd_valid_d;
  sched_cmd_type         cmd_q, cmd_d;
  logic                  ref_busy_q, ref_busy_d;

  logic                  cas_eff, pre_eff, act_eff, any_req, arb_en;
  logic                  ref_issue, ref_urgent;
  logic [REF_PEND_W-1:0] ref_pend;

  sched_refresh_timer #(
    .T_REFI       (T_REFI),
    .MAX_POSTPONE (MAX_POSTPONE)
  ) u_ref_timer (
    .clock_t     (clock_t),
    .reset_n     (reset_n),
    .ref_issue   (ref_issue),
    .ref_pending (ref_pend),
    .ref_urgent  (ref_urgent)
  );

  always_comb begin
    // The requester still holds req during its grant cycle; ignore it there so one
    // request yields exactly one grant.
    cas_eff = cas_req && !cas_gnt_q;
    pre_eff = pre_req && !pre_gnt_q;
    act_eff = act_req && !act_gnt_q && (rrd_q == '0);
    any_req = cas_req || pre_req || act_req;

    state_d     = state_q;
    tmr_d       = tmr_q;
    rrd_d       = (rrd_q != '0) ? rrd_q - RW'(1) : rrd_q;
    cas_gnt_d   = 1'b0;
    pre_gnt_d   = 1'b0;
    act_gnt_d   = 1'b0;
    cmd_valid_d = 1'b0;
    cmd_d       = CMD_NOP;
    ref_issue   = 1'b0;
    arb_en      = 1'b0;

    unique case (state_q)
      SCH_RUN: begin
        if (ref_urgent || (ref_pend != '0 && !any_req)) begin
          state_d = SCH_DRAIN;
        end else begin
          arb_en = 1'b1;
        end
      end
      SCH_DRAIN: begin
        // Open bursts finish; the raw req keeps the bus here until CAS traffic stops.
        if (cas_eff) begin
          cas_gnt_d   = 1'b1;
          cmd_valid_d = 1'b1;
          cmd_d       = cas_cmd(cas_rw);
        end else if (!cas_req) begin
          cmd_valid_d = 1'b1;
          cmd_d       = CMD_PREA;
          tmr_d       = '0;
          state_d     = SCH_TRP;
        end
      end
      SCH_TRP: begin
        if (tmr_q == TRP_LAST) begin
          cmd_valid_d = 1'b1;
          cmd_d       = CMD_REF;
          ref_issue   = 1'b1;
          tmr_d       = '0;
          state_d     = SCH_TRFC;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      SCH_TRFC: begin
        // Arbitrate in the last tRFC clock so the first grant lands exactly tRFC after REF.
        if (tmr_q == TRFC_LAST) begin
          state_d = SCH_RUN;
          arb_en  = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = SCH_RUN;
    endcase

    if (arb_en) begin
      if (cas_eff) begin
        cas_gnt_d   = 1'b1;
        cmd_valid_d = 1'b1;
        cmd_d       = cas_cmd(cas_rw);
      end else if (pre_eff) begin
        pre_gnt_d   = 1'b1;
        cmd_valid_d = 1'b1;
        cmd_d       = CMD_PRE;
      end else if (act_eff) begin
        act_gnt_d   = 1'b1;
        cmd_valid_d = 1'b1;
        cmd_d       = CMD_ACT;
        rrd_d       = RRD_LOAD;
      end
    end

    ref_busy_d = (state_d != SCH_RUN);
  end

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SCH_RUN;
      tmr_q       <= '0;
      rrd_q       <= '0;
      cas_gnt_q   <= 1'b0;
      pre_gnt_q   <= 1'b0;
      act_gnt_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      ref_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      rrd_q       <= rrd_d;
      cas_gnt_q   <= cas_gnt_d;
      pre_gnt_q   <= pre_gnt_d;
      act_gnt_q   <= act_gnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      ref_busy_q  <= ref_busy_d;
    end
  end

  assign cas_gnt     = cas_gnt_q;
  assign pre_gnt     = pre_gnt_q;
  assign act_gnt     = act_gnt_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd         = cmd_q;
  assign ref_busy    = ref_busy_q;
  assign ref_pending = ref_pend;

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Self-checking bench for ddr_cmd_sched (T_REFI shortened to 100 clocks).
// Latency: n/a.
// Backpressure: n/a.
module tb_ddr_cmd_sched;
  import ddr_package::*;

  logic       clock_t = 1'b0;
  logic       reset_n = 1'b0;
  logic       pre_req = 1'b0;
  logic       act_req = 1'b0;
  logic       cas_req = 1'b0;
  logic [1:0] cas_rw  = DDR_READ;
  logic       pre_gnt, act_gnt, cas_gnt, cmd_valid, ref_busy;
  logic [2:0] cmd;
  logic [3:0] ref_pending;

  always #5 clock_t = ~clock_t;

  ddr_cmd_sched #(
    .T_RRD        (4),
    .T_RP         (11),
    .T_RFC        (208),
    .T_REFI       (100),
    .MAX_POSTPONE (8)
  ) dut (
    .clock_t     (clock_t),
    .reset_n     (reset_n),
    .pre_req     (pre_req),
    .act_req     (act_req),
    .cas_req     (cas_req),
    .cas_rw      (cas_rw),
    .pre_gnt     (pre_gnt),
    .act_gnt     (act_gnt),
    .cas_gnt     (cas_gnt),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .ref_busy    (ref_busy),
    .ref_pending (ref_pending)
  );

  int checks   = 0;
  int failures = 0;
  int n        = 0;   // negedges since the last reset release

  typedef struct {
    logic       cas;
    logic       pre;
    logic       act;
    logic [1:0] rw;
    logic [2:0] gnt;   // {cas, pre, act}
    logic       vld;
    logic [2:0] cmd;
  } vec_t;

  vec_t       vecs[8];
  logic [2:0] prio_g[3];
  logic [2:0] prio_c[3];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock_t);
    n++;
  endtask

  task automatic drop_all();
    cas_req = 1'b0;
    pre_req = 1'b0;
    act_req = 1'b0;
  endtask

  task automatic do_reset();
    drop_all();
    cas_rw = DDR_READ;
    @(negedge clock_t);
    reset_n = 1'b0;
    repeat (2) @(negedge clock_t);
    reset_n = 1'b1;
    n = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},  int'({cas_gnt, pre_gnt, act_gnt}), 0);
    check({tag, "_vld"},  int'(cmd_valid), 0);
    check({tag, "_cmd"},  int'(cmd), int'(CMD_NOP));
    check({tag, "_busy"}, int'(ref_busy), 0);
    check({tag, "_pend"}, int'(ref_pending), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int base;
    int act_in_busy;
    int cas_in_drain;
    int cas_bad_cmd;

    //                 cas   pre   act   rw         {c,p,a} vld   cmd
    vecs[0] = '{1'b1, 1'b0, 1'b0, DDR_READ,  3'b100, 1'b1, CMD_RD};
    vecs[1] = '{1'b1, 1'b0, 1'b0, DDR_WRITE, 3'b100, 1'b1, CMD_WR};
    vecs[2] = '{1'b0, 1'b1, 1'b0, DDR_READ,  3'b010, 1'b1, CMD_PRE};
    vecs[3] = '{1'b0, 1'b0, 1'b1, DDR_READ,  3'b001, 1'b1, CMD_ACT};
    vecs[4] = '{1'b0, 1'b1, 1'b1, DDR_READ,  3'b010, 1'b1, CMD_PRE};
    vecs[5] = '{1'b1, 1'b0, 1'b1, DDR_READ,  3'b100, 1'b1, CMD_RD};
    vecs[6] = '{1'b1, 1'b1, 1'b1, DDR_WRITE, 3'b100, 1'b1, CMD_WR};
    vecs[7] = '{1'b0, 1'b0, 1'b0, DDR_READ,  3'b000, 1'b0, CMD_NOP};

    prio_g[0] = 3'b100; prio_c[0] = CMD_RD;
    prio_g[1] = 3'b010; prio_c[1] = CMD_PRE;
    prio_g[2] = 3'b001; prio_c[2] = CMD_ACT;

    // Reset values while reset is held from time 0.
    repeat (2) @(negedge clock_t);
    check_reset_outputs("por");

    // Single-request vectors: grant one clock after req, command lasts exactly one clock.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      cas_req = vecs[i].cas;
      pre_req = vecs[i].pre;
      act_req = vecs[i].act;
      cas_rw  = vecs[i].rw;
      tick();
      check($sformatf("vec%0d_gnt", i), int'({cas_gnt, pre_gnt, act_gnt}), int'(vecs[i].gnt));
      check($sformatf("vec%0d_vld", i), int'(cmd_valid), int'(vecs[i].vld));
      check($sformatf("vec%0d_cmd", i), int'(cmd), int'(vecs[i].cmd));
      drop_all();
      tick();
      check($sformatf("vec%0d_vld_next", i), int'(cmd_valid), 0);
    end

    // Held ACT: one grant every T_RRD=4 clocks starting at clock 1.
    do_reset();
    act_req = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      check($sformatf("rrd_gnt_c%0d", i), int'(act_gnt), (i % 4 == 1) ? 1 : 0);
      if (act_gnt) check($sformatf("rrd_cmd_c%0d", i), int'(cmd), int'(CMD_ACT));
    end
    drop_all();

    // All three together: CAS, PRE, ACT on consecutive clocks, each dropped after its grant.
    do_reset();
    cas_req = 1'b1;
    pre_req = 1'b1;
    act_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("prio%0d_gnt", i), int'({cas_gnt, pre_gnt, act_gnt}), int'(prio_g[i]));
      check($sformatf("prio%0d_cmd", i), int'(cmd), int'(prio_c[i]));
      if (cas_gnt) cas_req = 1'b0;
      if (pre_gnt) pre_req = 1'b0;
      if (act_gnt) act_req = 1'b0;
    end
    tick();
    check("prio_idle_vld", int'(cmd_valid), 0);

    // Idle refresh: wrap at clock 100, drain at 101, PREA at 102, REF at 113, busy clears at 321.
    do_reset();
    repeat (99) tick();
    check("idle_pend_c99", int'(ref_pending), 0);
    tick();
    check("idle_pend_c100", int'(ref_pending), 1);
    check("idle_busy_c100", int'(ref_busy), 0);
    tick();
    check("idle_busy_c101", int'(ref_busy), 1);
    check("idle_vld_c101", int'(cmd_valid), 0);
    tick();
    check("idle_prea_cmd", int'(cmd), int'(CMD_PREA));
    check("idle_prea_vld", int'(cmd_valid), 1);
    repeat (10) tick();
    check("idle_trp_quiet", int'(cmd_valid), 0);
    tick();
    check("idle_ref_cmd", int'(cmd), int'(CMD_REF));
    check("idle_ref_vld", int'(cmd_valid), 1);
    check("idle_ref_busy", int'(ref_busy), 1);
    check("idle_ref_pend", int'(ref_pending), 0);
    base = n;
    t = 0;
    while (ref_busy !== 1'b0 && t < 400) begin
      tick();
      t++;
    end
    check("idle_ref_to_busy_clear", n - base, 208);

    // Wraps at 200 and 300 owe two more refreshes; the second REF leaves one owed.
    t = 0;
    while (cmd !== CMD_REF && t < 60) begin
      tick();
      t++;
    end
    check("idle_ref2_seen", int'(cmd), int'(CMD_REF));
    check("idle_ref2_pend", int'(ref_pending), 1);

    // Reset three clocks into tRFC, hold it for three clocks.
    repeat (3) tick();
    reset_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("midtrfc");
    reset_n = 1'b1;
    tick();
    check("midtrfc_state", int'(dut.state_q), int'(SCH_RUN));
    check_reset_outputs("midtrfc_rel");
    act_req = 1'b1;
    tick();
    check("midtrfc_act_gnt", int'(act_gnt), 1);
    check("midtrfc_act_cmd", int'(cmd), int'(CMD_ACT));
    drop_all();

    // Held ACT keeps the bus busy until 8 refreshes are owed; then only CAS gets through.
    do_reset();
    act_req = 1'b1;
    t = 0;
    while (ref_pending !== 4'd8 && t < 1000) begin
      tick();
      t++;
    end
    check("sat_reach_cycle", n, 800);
    cas_rw  = DDR_WRITE;
    cas_req = 1'b1;
    act_in_busy  = 0;
    cas_in_drain = 0;
    cas_bad_cmd  = 0;
    while (n < 901) begin
      tick();
      if (ref_busy && act_gnt) act_in_busy++;
      if (cas_gnt) begin
        cas_in_drain++;
        if (cmd !== CMD_WR) cas_bad_cmd++;
      end
    end
    check("sat_hold_at_8", int'(ref_pending), 8);
    check("sat_busy_in_drain", int'(ref_busy), 1);
    repeat (4) tick();
    cas_req = 1'b0;
    t = 0;
    while (cmd !== CMD_REF && t < 40) begin
      tick();
      t++;
      if (ref_busy && act_gnt) act_in_busy++;
    end
    check("sat_ref_seen", int'(cmd), int'(CMD_REF));
    check("sat_pend_after_ref", int'(ref_pending), 7);
    check("sat_no_act_in_busy", act_in_busy, 0);
    check("sat_cas_granted", int'(cas_in_drain > 0), 1);
    check("sat_cas_cmd_wr", cas_bad_cmd, 0);
    drop_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
